// File: rtl/lathe_cycle_sequencer.sv
// Auto-cycle sequencer for the retrofitted lathe: spin-up, feed, dwell, retract, spin-down, with fault latching.
// Optional completed-part counter is built only when CYCLE_COUNTER_EN is defined.
module lathe_cycle_sequencer #(
    parameter int unsigned SPINUP_TICKS       = 150_000_000,
    parameter int unsigned DWELL_TICKS        = 50_000_000,
    parameter int unsigned SPINDOWN_TICKS     = 100_000_000,
    parameter int unsigned MOVE_TIMEOUT_TICKS = 500_000_000,
    parameter int          CNT_W              = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        start,
    input  logic        stop,
    input  logic        estop,
    input  logic        door_closed,
    input  logic        feed_limit,
    input  logic        home_limit,
    input  logic        fault_clear,
    output logic        spindle_on,
    output logic        coolant_on,
    output logic        feed_fwd,
    output logic        feed_rev,
    output logic        busy,
    output logic        cycle_done,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [2:0]  state,
    output logic [15:0] part_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPIN_UP   = 3'd1,
        S_FEED      = 3'd2,
        S_DWELL     = 3'd3,
        S_RETRACT   = 3'd4,
        S_SPIN_DOWN = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_ESTOP    = 3'd1;
    localparam logic [2:0] C_DOOR     = 3'd2;
    localparam logic [2:0] C_FEED_TO  = 3'd3;
    localparam logic [2:0] C_RETR_TO  = 3'd4;
    localparam logic [2:0] C_NOT_HOME = 3'd5;

    localparam logic [CNT_W-1:0] L_SPINUP_LAST   = CNT_W'(SPINUP_TICKS - 1);
    localparam logic [CNT_W-1:0] L_DWELL_LAST    = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] L_SPINDOWN_LAST = CNT_W'(SPINDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] L_MOVE_LAST     = CNT_W'(MOVE_TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] L_ONE           = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_timer;
    logic [2:0]         r_fault_code;
    logic               r_start_q;
    logic               r_spindle;
    logic               r_coolant;
    logic               r_fwd;
    logic               r_rev;
    logic               r_busy;
    logic               r_fault;
    logic               r_cycle_done;

    state_t             w_next_state;
    logic [2:0]         w_next_code;
    logic               w_start_rise;
    logic               w_cycle_end;

    assign w_start_rise = start & ~r_start_q;
    assign w_cycle_end  = (r_state == S_SPIN_DOWN) && (w_next_state == S_IDLE);

    // Safety trips outrank everything in a busy state; below them each state
    // resolves timeout, limit, stop and timer exit in that order.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fault_code;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    if (estop) begin
                        w_next_state = S_FAULT;
                        w_next_code  = C_ESTOP;
                    end else if (!door_closed) begin
                        w_next_state = S_FAULT;
                        w_next_code  = C_DOOR;
                    end else if (!home_limit) begin
                        w_next_state = S_FAULT;
                        w_next_code  = C_NOT_HOME;
                    end else begin
                        w_next_state = S_SPIN_UP;
                    end
                end
            end
            S_SPIN_UP, S_FEED, S_DWELL, S_RETRACT, S_SPIN_DOWN: begin
                if (estop) begin
                    w_next_state = S_FAULT;
                    w_next_code  = C_ESTOP;
                end else if (!door_closed) begin
                    w_next_state = S_FAULT;
                    w_next_code  = C_DOOR;
                end else begin
                    case (r_state)
                        S_SPIN_UP: begin
                            if (stop)
                                w_next_state = S_SPIN_DOWN;
                            else if (r_timer == L_SPINUP_LAST)
                                w_next_state = S_FEED;
                        end
                        S_FEED: begin
                            if (r_timer == L_MOVE_LAST) begin
                                w_next_state = S_FAULT;
                                w_next_code  = C_FEED_TO;
                            end else if (feed_limit) begin
                                w_next_state = S_DWELL;
                            end else if (stop) begin
                                w_next_state = S_RETRACT;
                            end
                        end
                        S_DWELL: begin
                            if (stop || (r_timer == L_DWELL_LAST))
                                w_next_state = S_RETRACT;
                        end
                        S_RETRACT: begin
                            if (r_timer == L_MOVE_LAST) begin
                                w_next_state = S_FAULT;
                                w_next_code  = C_RETR_TO;
                            end else if (home_limit) begin
                                w_next_state = S_SPIN_DOWN;
                            end
                        end
                        default: begin
                            if (r_timer == L_SPINDOWN_LAST)
                                w_next_state = S_IDLE;
                        end
                    endcase
                end
            end
            S_FAULT: begin
                if (fault_clear && !estop && door_closed && !start) begin
                    w_next_state = S_IDLE;
                    w_next_code  = C_NONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_code  = C_NONE;
            end
        endcase
    end

    // Actuator outputs are decoded from the next state so they move with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fault_code <= C_NONE;
            r_start_q    <= 1'b0;
            r_spindle    <= 1'b0;
            r_coolant    <= 1'b0;
            r_fwd        <= 1'b0;
            r_rev        <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_cycle_done <= 1'b0;
        end else if (ena) begin
            r_state      <= w_next_state;
            r_fault_code <= w_next_code;
            r_start_q    <= start;
            r_cycle_done <= w_cycle_end;
            if (w_next_state != r_state)
                r_timer <= '0;
            else
                r_timer <= r_timer + L_ONE;
            r_spindle <= 1'b0;
            r_coolant <= 1'b0;
            r_fwd     <= 1'b0;
            r_rev     <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
            case (w_next_state)
                S_SPIN_UP: begin
                    r_spindle <= 1'b1;
                    r_busy    <= 1'b1;
                end
                S_FEED: begin
                    r_spindle <= 1'b1;
                    r_coolant <= 1'b1;
                    r_fwd     <= 1'b1;
                    r_busy    <= 1'b1;
                end
                S_DWELL: begin
                    r_spindle <= 1'b1;
                    r_coolant <= 1'b1;
                    r_busy    <= 1'b1;
                end
                S_RETRACT: begin
                    r_spindle <= 1'b1;
                    r_coolant <= 1'b1;
                    r_rev     <= 1'b1;
                    r_busy    <= 1'b1;
                end
                S_SPIN_DOWN: r_busy  <= 1'b1;
                S_FAULT:     r_fault <= 1'b1;
                default:     r_busy  <= 1'b0;
            endcase
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [15:0] r_part_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_part_count <= 16'd0;
        else if (ena && w_cycle_end)
            r_part_count <= r_part_count + 16'd1;
    end

    assign part_count = r_part_count;
`else
    assign part_count = 16'd0;
`endif

    assign spindle_on = r_spindle;
    assign coolant_on = r_coolant;
    assign feed_fwd   = r_fwd;
    assign feed_rev   = r_rev;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign cycle_done = r_cycle_done;
    assign fault_code = r_fault_code;
    assign state      = r_state;

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Bench for lathe_cycle_sequencer with short presets: vector table plus a hand-written done-hold sequence.
// Expected part_count follows CYCLE_COUNTER_EN.
module tb_lathe_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset, ena, start, stop, estop, door_closed;
    logic        feed_limit, home_limit, fault_clear;
    logic        spindle_on, coolant_on, feed_fwd, feed_rev, busy;
    logic        cycle_done, fault;
    logic [2:0]  fault_code, state;
    logic [15:0] part_count;

    lathe_cycle_sequencer #(
        .SPINUP_TICKS       (4),
        .DWELL_TICKS        (3),
        .SPINDOWN_TICKS     (2),
        .MOVE_TIMEOUT_TICKS (10),
        .CNT_W              (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .start       (start),
        .stop        (stop),
        .estop       (estop),
        .door_closed (door_closed),
        .feed_limit  (feed_limit),
        .home_limit  (home_limit),
        .fault_clear (fault_clear),
        .spindle_on  (spindle_on),
        .coolant_on  (coolant_on),
        .feed_fwd    (feed_fwd),
        .feed_rev    (feed_rev),
        .busy        (busy),
        .cycle_done  (cycle_done),
        .fault       (fault),
        .fault_code  (fault_code),
        .state       (state),
        .part_count  (part_count)
    );

    always #5 clk = ~clk;

    // Input word: {reset, ena, start, stop, estop, door_closed, feed_limit, home_limit, fault_clear}
    typedef struct {
        logic [8:0] in;
        logic [2:0] st;
        logic [2:0] code;
        logic       done;
        string      nm;
    } vec_t;

    localparam logic [8:0] B0   = 9'b0_1_0_0_0_1_0_0_0;
    localparam logic [8:0] B1   = 9'b0_1_0_0_0_1_0_1_0;
    localparam logic [8:0] STH  = 9'b0_1_1_0_0_1_0_1_0;
    localparam logic [8:0] FL   = 9'b0_1_0_0_0_1_1_0_0;
    localparam logic [8:0] FC   = 9'b0_1_0_0_0_1_0_0_1;
    localparam logic [8:0] ES   = 9'b0_1_0_0_1_1_0_0_0;
    localparam logic [8:0] ESFC = 9'b0_1_0_0_1_1_0_0_1;
    localparam logic [8:0] STP  = 9'b0_1_0_1_0_1_0_0_0;
    localparam logic [8:0] SH0  = 9'b0_1_1_0_0_1_0_0_0;
    localparam logic [8:0] SHFC = 9'b0_1_1_0_0_1_0_0_1;
    localparam logic [8:0] SHF1 = 9'b0_1_1_0_0_1_0_1_1;
    localparam logic [8:0] FRZ  = 9'b0_0_1_1_1_1_0_0_0;
    localparam logic [8:0] RST  = 9'b1_1_0_0_0_1_0_0_0;
    localparam logic [8:0] ESD  = 9'b0_1_0_0_1_0_0_0_0;
    localparam logic [8:0] DFC  = 9'b0_1_0_0_0_0_0_0_1;
    localparam logic [8:0] SD0  = 9'b0_1_1_0_0_0_0_1_0;
    localparam logic [8:0] HOLD = 9'b0_0_0_0_0_1_0_1_0;

    localparam logic [2:0] I = 3'd0, SU = 3'd1, F = 3'd2, D = 3'd3;
    localparam logic [2:0] R = 3'd4, SD = 3'd5, FT = 3'd6;

    vec_t        tbl[$];
    logic [28:0] exp_q[$];
    logic [15:0] exp_pc;
    int          n_cmp;
    int          n_mis;

    // {spindle_on, coolant_on, feed_fwd, feed_rev, busy, fault} for each state.
    function automatic logic [5:0] acts(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b100010;
            3'd2:    return 6'b111010;
            3'd3:    return 6'b110010;
            3'd4:    return 6'b110110;
            3'd5:    return 6'b000010;
            3'd6:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [8:0] in, input logic [2:0] st,
                                input logic [2:0] code, input logic done, input string nm);
        vec_t v;
        v.in   = in;
        v.st   = st;
        v.code = code;
        v.done = done;
        v.nm   = nm;
        return v;
    endfunction

    task automatic add(input logic [8:0] in, input logic [2:0] st, input logic [2:0] code,
                       input logic done, input string nm, input int n);
        for (int k = 0; k < n; k++)
            tbl.push_back(mk(in, st, code, done, nm));
    endtask

    task automatic check(input string nm);
        logic [28:0] got;
        logic [28:0] exp;
        got = {state, fault_code, cycle_done, spindle_on, coolant_on, feed_fwd, feed_rev,
               busy, fault, part_count};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL %s: no expected entry queued, got state=%0d", nm, state);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_mis++;
                $display("FAIL %s: got st=%0d code=%0d done=%b acts=%b pc=%0d, need st=%0d code=%0d done=%b acts=%b pc=%0d",
                         nm, got[28:26], got[25:23], got[22], got[21:16], got[15:0],
                         exp[28:26], exp[25:23], exp[22], exp[21:16], exp[15:0]);
            end
        end
        n_cmp++;
        if (feed_fwd && feed_rev) begin
            n_mis++;
            $display("FAIL %s_interlock: got fwd=1 rev=1, need never both", nm);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {reset, ena, start, stop, estop, door_closed, feed_limit, home_limit, fault_clear} = v.in;
        if (v.in[8])
            exp_pc = 16'd0;
`ifdef CYCLE_COUNTER_EN
        else if (v.in[7] && v.done)
            exp_pc = exp_pc + 16'd1;
`endif
        exp_q.push_back({v.st, v.code, v.done, acts(v.st), exp_pc});
        @(posedge clk);
        #1;
        check(v.nm);
    endtask

    initial begin
        n_cmp  = 0;
        n_mis  = 0;
        exp_pc = 16'd0;
        {reset, ena, start, stop, estop, door_closed, feed_limit, home_limit, fault_clear} = RST;

        // Full pass: feed limit on FEED cycle 5, home on RETRACT cycle 2.
        add(9'b1_0_0_0_0_1_0_1_0, I, 0, 0, "reset", 1);
        add(B1,   I,  0, 0, "idle", 1);
        add(STH,  SU, 0, 0, "start_edge", 1);
        add(B0,   SU, 0, 0, "spin_up", 3);
        add(B0,   F,  0, 0, "feed_entry", 1);
        add(B0,   F,  0, 0, "feed", 4);
        add(FL,   D,  0, 0, "feed_limit", 1);
        add(B0,   D,  0, 0, "dwell", 2);
        add(B0,   R,  0, 0, "retract_entry", 2);
        add(B1,   SD, 0, 0, "home_reached", 2);
        add(B1,   I,  0, 1, "cycle_done", 1);
        add(B1,   I,  0, 0, "done_pulse_end", 1);
        // Feed timeout then clear.
        add(STH,  SU, 0, 0, "start2", 1);
        add(B0,   SU, 0, 0, "spin_up2", 3);
        add(B0,   F,  0, 0, "feed_wait", 10);
        add(B0,   FT, 3, 0, "feed_timeout", 1);
        add(FC,   I,  0, 0, "clear_timeout", 1);
        add(B0,   I,  0, 0, "idle2", 1);
        // E-stop in DWELL; clear blocked while estop active.
        add(STH,  SU, 0, 0, "start3", 1);
        add(B0,   SU, 0, 0, "spin_up3", 3);
        add(B0,   F,  0, 0, "feed3", 1);
        add(FL,   D,  0, 0, "limit_on_entry", 1);
        add(ES,   FT, 1, 0, "estop_dwell", 1);
        add(ESFC, FT, 1, 0, "clear_blocked_estop", 1);
        add(FC,   I,  0, 0, "clear_estop", 1);
        // Stop during FEED.
        add(STH,  SU, 0, 0, "start4", 1);
        add(B0,   SU, 0, 0, "spin_up4", 3);
        add(B0,   F,  0, 0, "feed4", 2);
        add(STP,  R,  0, 0, "stop_feed", 1);
        add(B0,   R,  0, 0, "retract4", 1);
        add(B1,   SD, 0, 0, "spin_down4", 2);
        add(B1,   I,  0, 1, "cycle_done4", 1);
        add(B1,   I,  0, 0, "idle4", 1);
        // Not home at start; start held through clear.
        add(B0,   I,  0, 0, "idle5", 1);
        add(SH0,  FT, 5, 0, "not_home", 1);
        add(SHFC, FT, 5, 0, "start_held_clear", 1);
        add(SHF1, FT, 5, 0, "start_held_home", 1);
        add(FC,   I,  0, 0, "clear_not_home", 1);
        add(B0,   I,  0, 0, "idle6", 1);
        // ena freeze in SPIN_UP, then reset mid-RETRACT.
        add(STH,  SU, 0, 0, "start7", 1);
        add(B0,   SU, 0, 0, "spin_up7", 1);
        add(FRZ,  SU, 0, 0, "ena_freeze", 5);
        add(B0,   SU, 0, 0, "spin_up_resume", 2);
        add(B0,   F,  0, 0, "feed_after_freeze", 1);
        add(STP,  R,  0, 0, "stop_feed7", 1);
        add(B0,   R,  0, 0, "retract7", 1);
        add(RST,  I,  0, 0, "reset_retract", 1);
        add(B1,   I,  0, 0, "idle8", 1);
        // Simultaneous estop/door, door-open start.
        add(STH,  SU, 0, 0, "start9", 1);
        add(ESD,  FT, 1, 0, "estop_and_door", 1);
        add(DFC,  FT, 1, 0, "clear_blocked_door", 1);
        add(FC,   I,  0, 0, "clear9", 1);
        add(SD0,  FT, 2, 0, "door_open_start", 1);
        add(FC,   I,  0, 0, "clear_door", 1);
        // Stop during SPIN_UP.
        add(STH,  SU, 0, 0, "start10", 1);
        add(STP,  SD, 0, 0, "stop_spin_up", 1);
        add(B0,   SD, 0, 0, "spin_down10", 1);
        add(B0,   I,  0, 1, "done_after_stop", 1);
        // Retract timeout.
        add(STH,  SU, 0, 0, "start11", 1);
        add(B0,   SU, 0, 0, "spin_up11", 3);
        add(B0,   F,  0, 0, "feed11", 1);
        add(FL,   D,  0, 0, "limit11", 1);
        add(B0,   D,  0, 0, "dwell11", 2);
        add(B0,   R,  0, 0, "retract_wait", 10);
        add(B0,   FT, 4, 0, "retract_timeout", 1);
        add(FC,   I,  0, 0, "clear11", 1);

        foreach (tbl[i])
            apply(tbl[i]);

        // A pending cycle_done pulse is held while ena is low.
        apply(mk(STH,  SU, 0, 0, "h_start"));
        for (int k = 0; k < 3; k++)
            apply(mk(B0, SU, 0, 0, "h_spin_up"));
        apply(mk(B0,   F,  0, 0, "h_feed"));
        apply(mk(FL,   D,  0, 0, "h_limit"));
        apply(mk(B0,   D,  0, 0, "h_dwell"));
        apply(mk(B0,   D,  0, 0, "h_dwell"));
        apply(mk(B0,   R,  0, 0, "h_retract"));
        apply(mk(B1,   SD, 0, 0, "h_home"));
        apply(mk(B1,   SD, 0, 0, "h_spin_down"));
        apply(mk(B1,   I,  0, 1, "h_done"));
        apply(mk(HOLD, I,  0, 1, "h_done_frozen"));
        apply(mk(HOLD, I,  0, 1, "h_done_frozen"));
        apply(mk(B1,   I,  0, 0, "h_done_release"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lathe_cycle_sequencer.md
Name: lathe_cycle_sequencer

Overview:
- Auto-cycle controller for the retrofitted manual lathe. It sequences spindle, coolant and carriage feed through one machining pass: spin-up delay, feed to limit, dwell, retract to home, spin-down.
- It supervises e-stop, the door interlock and feed/retract timeouts, and latches faults until an operator clear.
- It sits between the operator panel inputs and the actuator drive outputs, alongside the existing start/mode TON controller.

Parameters:
SPINUP_TICKS, 150_000_000, cycles spindle runs before feed starts (3 s @ 50 MHz)
DWELL_TICKS, 50_000_000, cycles held at feed limit
SPINDOWN_TICKS, 100_000_000, cycles after spindle-off before cycle_done
MOVE_TIMEOUT_TICKS, 500_000_000, max cycles allowed in FEED or RETRACT
CNT_W, 32, timer counter width; must hold the largest preset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ena  in  1  1 = advance; 0 = freeze state, timer and outputs
start  in  1  cycle start button, rising-edge detected
stop  in  1  orderly stop request, level
estop  in  1  emergency stop, level, 1 = active
door_closed  in  1  guard interlock, 1 = safe
feed_limit  in  1  carriage at end-of-cut limit
home_limit  in  1  carriage at home position
fault_clear  in  1  operator fault acknowledge, level
spindle_on  out  1  spindle contactor
coolant_on  out  1  coolant pump
feed_fwd  out  1  carriage feed toward limit
feed_rev  out  1  carriage retract toward home
busy  out  1  1 in any state except IDLE and FAULT
cycle_done  out  1  one-cycle pulse on SPIN_DOWN -> IDLE
fault  out  1  1 while in FAULT
fault_code  out  3  latched cause: 0 none, 1 estop, 2 door, 3 feed timeout, 4 retract timeout, 5 not home at start
state  out  3  encoded state, for debug and LEDs
part_count  out  16  completed cycles (see Optional Feature)

Behaviour:
- All logic is on posedge clk. reset is sampled synchronously and has highest priority.
- Reset values: state = IDLE, timer = 0, fault_code = 0, start edge register = 0, part_count = 0. All outputs are 0.
- ena = 0: nothing changes, including the start edge register and any pending cycle_done. It takes effect only after reset.
- State encoding: IDLE 0, SPIN_UP 1, FEED 2, DWELL 3, RETRACT 4, SPIN_DOWN 5, FAULT 6.
- Outputs are registered and decoded from the next state, so they change in the same cycle as state.
- Output decode by state:
  - SPIN_UP: spindle_on.
  - FEED and DWELL: spindle_on, coolant_on, plus feed_fwd in FEED only.
  - RETRACT: spindle_on, coolant_on, feed_rev.
  - IDLE, SPIN_DOWN and FAULT: all actuators 0.
- feed_fwd and feed_rev are never 1 together.
- Timer: cleared on every state entry and increments each enabled cycle. A timed state exits when timer == PRESET-1, so it lasts exactly PRESET cycles.
- IDLE exit on a start rising edge (start = 1 now, 0 in the previous enabled cycle):
  - estop = 1 -> FAULT, code 1.
  - Otherwise door_closed = 0 -> FAULT, code 2.
  - Otherwise home_limit = 0 -> FAULT, code 5.
  - Otherwise -> SPIN_UP.
- SPIN_UP -> FEED after SPINUP_TICKS.
- FEED:
  - feed_limit = 1 -> DWELL.
  - Timer reaches MOVE_TIMEOUT_TICKS-1 first -> FAULT, code 3.
  - feed_limit already 1 on entry -> DWELL on the next cycle.
- DWELL -> RETRACT after DWELL_TICKS.
- RETRACT:
  - home_limit = 1 -> SPIN_DOWN.
  - Timeout -> FAULT, code 4.
- SPIN_DOWN -> IDLE after SPINDOWN_TICKS. cycle_done pulses for 1 cycle, registered with the IDLE entry.
- Priority each cycle in a busy state:
  1. estop (code 1)
  2. door open (code 2)
  3. timeout
  4. limit exit
  5. stop
  6. timer exit
- If estop and door open occur together, code 1 is recorded.
- stop = 1:
  - In SPIN_UP -> SPIN_DOWN.
  - In FEED or DWELL -> RETRACT.
  - In RETRACT and SPIN_DOWN it has no effect (these states already complete the stop).
  - In IDLE it is ignored.
- FAULT holds all actuators at 0 and fault_code latched.
- FAULT exit -> IDLE requires all of: fault_clear = 1, estop = 0, door_closed = 1, start = 0. On exit, fault_code clears to 0.
- A start held high across a fault clear does not restart the cycle; a fresh rising edge is required.

Optional Feature:
- Macro: CYCLE_COUNTER_EN.
- Defined: part_count increments by 1 on each cycle_done pulse, wraps 0xFFFF -> 0x0000, and clears only on reset.
- Undefined: part_count is tied to 0 and no counter register is built.

Test Plan:
- SPINUP=4, DWELL=3, SPINDOWN=2, TIMEOUT=10, home = 1, door = 1; start pulse; feed_limit high at FEED cycle 5; home_limit high at RETRACT cycle 2. Required response: spindle_on high 1 cycle after the start edge; FEED entered after exactly 4 cycles; DWELL lasts 3 cycles; cycle_done pulses once; part_count = 1 when CYCLE_COUNTER_EN is defined.
- FEED with feed_limit held 0 -> FAULT on FEED cycle 10, fault_code = 3, all actuators 0. Then fault_clear with start = 0 -> IDLE, fault_code = 0.
- estop asserted in DWELL -> FAULT next cycle, code 1. fault_clear while estop is still 1 -> stays in FAULT. Deassert estop -> IDLE.
- stop pulse during FEED -> RETRACT with feed_rev = 1 and feed_fwd = 0 in the same cycle; home_limit -> SPIN_DOWN -> IDLE with cycle_done.
- start edge with home_limit = 0 -> FAULT, code 5. Holding start through fault_clear does not begin a cycle.
- ena = 0 for 5 cycles mid SPIN_UP -> timer and outputs frozen; SPIN_UP still lasts 4 enabled cycles. reset mid-RETRACT -> all outputs 0 and state = 0 on the next edge.
